fifo_ctrl_2p: RTL
=================

Name: fifo_ctrl_2p

Overview:
- Synchronous FIFO controller that owns an external two-port RAM (DEPTH x WIDTH, registered read, 1-cycle read latency, separate read/write enables and addresses).
- Converts the RAM into a valid/ready stream FIFO, sitting between a producer stage and a consumer stage.
- Hides the RAM read latency with a 3-entry output prefetch buffer, so the FIFO sustains one word per cycle in and out.
- Instantiated as the buffering stage next to every two-port memory macro in the datapath.

Parameters:
- DEPTH, 2048, RAM word count; any value >= 2, not required to be a power of two.
- WIDTH, 24, data width in bits.
- A (localparam), max($clog2(DEPTH),1), RAM address width.
- C (localparam), $clog2(DEPTH+4), occupancy counter width.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  WIDTH  producer word.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the head word.
- out_data  out  WIDTH  head word.
- mem_addrw  out  A  RAM write address.
- mem_mew  out  1  RAM write enable.
- mem_din  out  WIDTH  RAM write data.
- mem_addrr  out  A  RAM read address.
- mem_mer  out  1  RAM read enable.
- mem_dout  in  WIDTH  RAM registered read data; valid in the cycle after mem_mer.
- count  out  C  total words held (RAM + in-flight read + output buffer).

Behaviour:
- Reset (async, while rst=1): wptr=0, rptr=0, ram_cnt=0, rd_pend=0, obuf_cnt=0.
  - Outputs during reset: out_valid=0, in_ready=0, mem_mew=0, mem_mer=0, count=0, out_data=0.
- Reset mid-operation discards all stored data and any in-flight read. The mem_dout that follows is ignored.
- Write side:
  - in_ready = !rst && (ram_cnt < DEPTH).
  - push = in_valid && in_ready.
  - Combinational mapping: mem_mew=push, mem_addrw=wptr, mem_din=in_data.
  - wptr increments on push and wraps from DEPTH-1 to 0.
- Read issue:
  - mem_mer = (ram_cnt != 0) && (obuf_cnt + rd_pend < 3).
  - mem_addrr = rptr; rptr increments on mem_mer, same wrap rule.
  - rd_pend <= mem_mer (register).
- Capture: when rd_pend=1, mem_dout is written into the output buffer tail at that clock edge.
- Output buffer:
  - 3-entry FIFO of registers; out_valid = (obuf_cnt != 0); out_data = head entry.
  - pop = out_valid && out_ready.
  - Capture and pop in the same cycle leave obuf_cnt unchanged.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- ram_cnt: next = ram_cnt + push - mem_mer.
  - A word written in cycle n is not readable until cycle n+1, so the RAM never sees read and write to the same address in one cycle for the same word. No bypass path.
- count: next = count + push - pop; range 0..DEPTH+3.
- Latency: word pushed in cycle n -> mem_mer in n+1 -> captured end of n+2 -> out_valid in cycle n+3 (empty FIFO).
- Throughput: 1 word/cycle sustained when out_ready=1.
- Full: ram_cnt=DEPTH forces in_ready=0.
  - A pop that lets a prefetch issue frees a RAM slot, and in_ready rises the following cycle.
- Simultaneous push and mem_mer when ram_cnt=DEPTH is impossible, because in_ready=0.
- Simultaneous push and pop at any level keeps count constant.
- Empty: out_valid=0; out_ready is ignored.
- No overflow/underflow possible through the handshake. Inputs presented with in_valid=1 while in_ready=0 are not accepted and must be held by the producer.

Test Plan:
- Reset then one push (in_data=0xABCDEF) with out_ready=1 -> mem_mew in cycle 0 at addr 0, mem_mer at addr 0 in cycle 1, out_valid=1 with out_data=0xABCDEF in cycle 3, count back to 0 after pop.
- Stream of 100 incrementing words, in_valid=out_ready=1 continuously -> after 3-cycle fill, one word out per cycle, in order 0..99, in_ready never drops.
- DEPTH=4, out_ready=0, push 10 words -> exactly 7 accepted (4 RAM + 3 buffer), count=7, in_ready=0. Then out_ready=1 -> words 0..6 emerge in order.
- DEPTH=5, push/pop 13 words with random out_ready stalls -> both pointers wrap 4->0, data order preserved, out_data stable during every stall.
- Assert rst for 1 cycle while count=6 and a read is in flight -> out_valid=0 and count=0 immediately. The next push of 0x000055 emerges as the first word, and no stale data appears.
- Alternating out_ready 1/0 with continuous input -> in_ready and count settle without an overflow, and no word is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/fifo_ctrl_2p.sv
// fifo_ctrl_2p: valid/ready stream FIFO built around an external two-port RAM
// with a registered (1-cycle latency) read port. A 3-entry register buffer in
// front of the consumer absorbs the read latency so the FIFO moves one word
// per cycle in each direction.
module fifo_ctrl_2p #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 24,
  localparam int A = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int C = $clog2(DEPTH + 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [A-1:0]     mem_addrw,
  output logic             mem_mew,
  output logic [WIDTH-1:0] mem_din,
  output logic [A-1:0]     mem_addrr,
  output logic             mem_mer,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [C-1:0]     count
);

  logic [A-1:0]     wptr_r;
  logic [A-1:0]     rptr_r;
  logic [C-1:0]     ram_cnt_r;
  logic [C-1:0]     count_r;
  logic             rd_pend_r;
  logic [1:0]       obuf_cnt_r;
  logic [1:0]       obuf_cnt_s;
  logic [WIDTH-1:0] obuf_r [3];
  logic [WIDTH-1:0] obuf_s [3];
  logic             push_s;
  logic             pop_s;
  logic             mer_s;

  // RAM pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [A-1:0] ptr_inc(input logic [A-1:0] p);
    if (p == A'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + A'(1);
    end
  endfunction

  // Handshakes. in_ready is gated by rst so nothing is accepted during reset.
  assign in_ready  = !rst && (ram_cnt_r < C'(DEPTH));
  assign push_s    = in_valid && in_ready;
  assign out_valid = (obuf_cnt_r != 2'd0);
  assign pop_s     = out_valid && out_ready;

  // Prefetch only while the buffer plus the in-flight read leaves room.
  assign mer_s = (ram_cnt_r != '0) &&
                 (({1'b0, obuf_cnt_r} + {2'b00, rd_pend_r}) < 3'd3);

  assign mem_mew   = push_s;
  assign mem_addrw = wptr_r;
  assign mem_din   = in_data;
  assign mem_mer   = mer_s;
  assign mem_addrr = rptr_r;
  assign out_data  = obuf_r[0];
  assign count     = count_r;

  // Output buffer next state: shift out the head on pop, then append the
  // returning RAM word at the first free slot (never overflows by mer_s).
  always_comb begin
    obuf_s     = obuf_r;
    obuf_cnt_s = obuf_cnt_r;
    if (pop_s) begin
      obuf_s[0]  = obuf_r[1];
      obuf_s[1]  = obuf_r[2];
      obuf_cnt_s = obuf_cnt_s - 2'd1;
    end else begin
      obuf_cnt_s = obuf_cnt_r;
    end
    if (rd_pend_r) begin
      case (obuf_cnt_s)
        2'd0:    obuf_s[0] = mem_dout;
        2'd1:    obuf_s[1] = mem_dout;
        2'd2:    obuf_s[2] = mem_dout;
        default: obuf_s[0] = obuf_s[0];
      endcase
      obuf_cnt_s = obuf_cnt_s + 2'd1;
    end else begin
      obuf_cnt_s = obuf_cnt_s;
    end
  end

  // Pointers, RAM occupancy, in-flight read flag and total word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      ram_cnt_r <= '0;
      count_r   <= '0;
      rd_pend_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (mer_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      ram_cnt_r <= ram_cnt_r + C'(push_s) - C'(mer_s);
      count_r   <= count_r + C'(push_s) - C'(pop_s);
      rd_pend_r <= mer_s;
    end
  end

  // Output buffer registers; cleared on reset so out_data reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_r     <= '{default: '0};
      obuf_cnt_r <= 2'd0;
    end else begin
      obuf_r     <= obuf_s;
      obuf_cnt_r <= obuf_cnt_s;
    end
  end

endmodule
